conv_mac_sequencer: RTL and testbench

//  Sequences the shared convolution MAC datapath for one conv layer: per output pixel, walks all

---
 rtl/conv_mac_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// Convolution MAC sequencer: per output pixel, issues IN_CHANNELS window/weight pairs per output channel
// and hands each MAC result to the batch-norm FIFO. Optional mac_done watchdog: define MAC_WDOG_EN.
module conv_mac_sequencer #(
   parameter int IN_CHANNELS  = 4,
   parameter int OUT_CHANNELS = 8,
   parameter int IMAGE_WIDTH  = 188,
   parameter int IMAGE_HEIGHT = 120,
   parameter int DATA_WIDTH   = 16,
   parameter int WDOG_CYCLES  = 64,
   localparam int ADDR_W = (IN_CHANNELS * OUT_CHANNELS > 1) ? $clog2(IN_CHANNELS * OUT_CHANNELS) : 1,
   localparam int CH_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1,
   localparam int OC_W   = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  win_valid,
   output logic                  win_advance,
   output logic [ADDR_W-1:0]     wgt_addr,
   output logic [CH_W-1:0]       ch_sel,
   output logic                  mac_start,
   input  logic                  mac_done,
   input  logic [DATA_WIDTH-1:0] mac_result,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [OC_W-1:0]       res_oc,
   output logic                  busy,
   output logic                  frame_done
`ifdef MAC_WDOG_EN
   ,
   output logic                  wdog_err
`endif
);

   localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_WIN  = 3'd1,
      S_ADDR      = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_OUTPUT    = 3'd5,
      S_ADVANCE   = 3'd6
   } state_t;

   state_t             state_r, state_s;
   logic [CH_W-1:0]    ic_r, ic_s;
   logic [OC_W-1:0]    oc_r, oc_s;
   logic [COL_W-1:0]   col_r, col_s;
   logic [ROW_W-1:0]   row_r, row_s;
   logic [ADDR_W-1:0]  addr_s;
   logic [CH_W-1:0]    ch_sel_s;
   logic               capture_s;
   logic               last_pix_s;

`ifdef MAC_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0]    wdog_cnt_r;
   logic               wdog_fire_s;
   logic               clear_err_s;
`endif

   // Next-state, counter stepping and next values of the registered outputs
   always_comb begin
      state_s    = state_r;
      ic_s       = ic_r;
      oc_s       = oc_r;
      col_s      = col_r;
      row_s      = row_r;
      capture_s  = 1'b0;
      last_pix_s = (col_r == COL_W'(IMAGE_WIDTH - 1)) && (row_r == ROW_W'(IMAGE_HEIGHT - 1));
`ifdef MAC_WDOG_EN
      wdog_fire_s = 1'b0;
      clear_err_s = 1'b0;
`endif
      case (state_r)
         S_IDLE: begin
            if (frame_start) begin
               state_s = S_WAIT_WIN;
               ic_s    = CH_W'(0);
               oc_s    = OC_W'(0);
               col_s   = COL_W'(0);
               row_s   = ROW_W'(0);
`ifdef MAC_WDOG_EN
               clear_err_s = 1'b1;
`endif
            end else begin
               state_s = S_IDLE;
            end
         end
         S_WAIT_WIN: begin
            if (win_valid) begin
               state_s = S_ADDR;
            end else begin
               state_s = S_WAIT_WIN;
            end
         end
         S_ADDR: begin
            state_s = S_ISSUE;
            ic_s    = CH_W'(0);
         end
         S_ISSUE: begin
            if (ic_r == CH_W'(IN_CHANNELS - 1)) begin
               ic_s    = CH_W'(0);
               state_s = S_WAIT_DONE;
            end else begin
               ic_s    = ic_r + CH_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (mac_done) begin
               capture_s = 1'b1;
               state_s   = S_OUTPUT;
            end else begin
`ifdef MAC_WDOG_EN
               if (wdog_cnt_r == WD_W'(WDOG_CYCLES - 1)) begin
                  wdog_fire_s = 1'b1;
                  state_s     = S_IDLE;
               end else begin
                  state_s = S_WAIT_DONE;
               end
`else
               state_s = S_WAIT_DONE;
`endif
            end
         end
         S_OUTPUT: begin
            // Same window is reused for every output channel; only the last one advances the pixel
            if (res_ready) begin
               if (oc_r == OC_W'(OUT_CHANNELS - 1)) begin
                  oc_s    = OC_W'(0);
                  state_s = S_ADVANCE;
               end else begin
                  oc_s    = oc_r + OC_W'(1);
                  state_s = S_ADDR;
               end
            end else begin
               state_s = S_OUTPUT;
            end
         end
         S_ADVANCE: begin
            if (col_r == COL_W'(IMAGE_WIDTH - 1)) begin
               col_s = COL_W'(0);
               if (row_r == ROW_W'(IMAGE_HEIGHT - 1)) begin
                  row_s = ROW_W'(0);
               end else begin
                  row_s = row_r + ROW_W'(1);
               end
            end else begin
               col_s = col_r + COL_W'(1);
            end
            if (last_pix_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_WAIT_WIN;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      // ROM read is one cycle behind, so the address leads ch_sel by one channel
      addr_s   = wgt_addr;
      ch_sel_s = ch_sel;
      if (state_s == S_ADDR) begin
         addr_s = ADDR_W'(oc_s) * ADDR_W'(IN_CHANNELS);
      end else if (state_s == S_ISSUE) begin
         ch_sel_s = ic_s;
         if (ic_s == CH_W'(IN_CHANNELS - 1)) begin
            addr_s = ADDR_W'(oc_s) * ADDR_W'(IN_CHANNELS) + ADDR_W'(IN_CHANNELS - 1);
         end else begin
            addr_s = ADDR_W'(oc_s) * ADDR_W'(IN_CHANNELS) + ADDR_W'(ic_s) + ADDR_W'(1);
         end
      end else begin
         addr_s = wgt_addr;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         ic_r        <= CH_W'(0);
         oc_r        <= OC_W'(0);
         col_r       <= COL_W'(0);
         row_r       <= ROW_W'(0);
         wgt_addr    <= ADDR_W'(0);
         ch_sel      <= CH_W'(0);
         mac_start   <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= DATA_WIDTH'(0);
         res_oc      <= OC_W'(0);
         busy        <= 1'b0;
         win_advance <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state_r     <= state_s;
         ic_r        <= ic_s;
         oc_r        <= oc_s;
         col_r       <= col_s;
         row_r       <= row_s;
         wgt_addr    <= addr_s;
         ch_sel      <= ch_sel_s;
         mac_start   <= (state_r == S_ADDR);
         res_valid   <= (state_s == S_OUTPUT);
         busy        <= (state_s != S_IDLE);
         win_advance <= (state_s == S_ADVANCE);
         frame_done  <= (state_s == S_ADVANCE) && last_pix_s;
         if (capture_s) begin
            res_data <= mac_result;
            res_oc   <= oc_r;
         end else begin
            res_data <= res_data;
            res_oc   <= res_oc;
         end
      end
   end

`ifdef MAC_WDOG_EN
   // Watchdog: counts cycles spent in WAIT_DONE; error is sticky until reset or an accepted frame_start
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_r <= WD_W'(0);
         wdog_err   <= 1'b0;
      end else begin
         if (state_r == S_WAIT_DONE) begin
            wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
         end else begin
            wdog_cnt_r <= WD_W'(0);
         end
         if (wdog_fire_s) begin
            wdog_err <= 1'b1;
         end else if (clear_err_s) begin
            wdog_err <= 1'b0;
         end else begin
            wdog_err <= wdog_err;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer (IN=4, OUT=2, W=4, H=2). A MAC model answers each mac_start
// two cycles after the last channel and queues the expected result; a monitor checks every presented result.
module tb_conv_mac_sequencer;
   localparam int IN = 4, OUT = 2, W = 4, H = 2, DW = 16, WD = 8, MAC_D = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, frame_start, win_valid, mac_done, res_ready;
   logic [DW-1:0] mac_result;
   logic          win_advance, mac_start, res_valid, busy, frame_done;
   logic [2:0]    wgt_addr;
   logic [1:0]    ch_sel;
   logic [DW-1:0] res_data;
   logic [0:0]    res_oc;
`ifdef MAC_WDOG_EN
   logic          wdog_err;
`endif

   conv_mac_sequencer #(
      .IN_CHANNELS(IN), .OUT_CHANNELS(OUT), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
      .DATA_WIDTH(DW), .WDOG_CYCLES(WD)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .win_valid(win_valid),
      .win_advance(win_advance), .wgt_addr(wgt_addr), .ch_sel(ch_sel), .mac_start(mac_start),
      .mac_done(mac_done), .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_oc(res_oc), .busy(busy), .frame_done(frame_done)
`ifdef MAC_WDOG_EN
      , .wdog_err(wdog_err)
`endif
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [0:0]    oc;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0, errors = 0;
   int            model_oc = 0, model_pix = 0;
   int            accepts = 0, adv_cnt = 0, fd_cnt = 0;
   logic          override_en = 1'b0, mac_silent = 1'b0;
   logic [DW-1:0] override_val = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic sel(input int which);
      case (which)
         0: sel = frame_done;
         1: sel = res_valid;
         2: sel = mac_start;
         3: sel = win_advance;
`ifdef MAC_WDOG_EN
         4: sel = wdog_err;
`endif
         default: sel = 1'b0;
      endcase
   endfunction

   task automatic wait_high(input int which, input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sel(which) && n < budget);
      checks++;
      if (!sel(which)) begin
         errors++;
         $display("FAIL %s: signal still 0 after %0d cycles, expected 1", name, budget);
      end
   endtask

   task automatic start_frame();
      model_oc  = 0;
      model_pix = 0;
      accepts   = 0;
      adv_cnt   = 0;
      fd_cnt    = 0;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic end_of_frame(input string tag);
      repeat (3) @(negedge clk);
      check({tag, "_win_adv_count"}, adv_cnt, 8);
      check({tag, "_frame_done_count"}, fd_cnt, 1);
      check({tag, "_accepts"}, accepts, 16);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   // MAC model: checks the ISSUE trace, then returns mac_done MAC_D cycles after the last channel
   initial begin
      logic [2:0] last_addr;
      int         base;
      bit         aborted;
      exp_t       e;
      last_addr = 3'd0;
      mac_done  = 1'b0;
      mac_result = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst && mac_start) begin
            base    = model_oc * IN;
            aborted = 1'b0;
            check("trace_addr_pre", last_addr, base);
            check("trace_ch0", ch_sel, 0);
            check("trace_addr_k0", wgt_addr, base + 1);
            for (int k = 1; k < IN; k++) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
               if (!aborted) begin
                  check("trace_ch", ch_sel, k);
                  check("trace_addr", wgt_addr, (k == IN - 1) ? base + IN - 1 : base + k + 1);
                  check("trace_single_start", mac_start, 0);
               end
            end
            for (int d = 0; d < MAC_D; d++) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
            end
            if (!aborted && !mac_silent) begin
               if (override_en) begin
                  e.data      = override_val;
                  override_en = 1'b0;
               end else begin
                  e.data = 16'(16'h0A00 + model_pix * 16 + model_oc * 3);
               end
               e.oc = 1'(model_oc);
               sb.push_back(e);
               mac_done   = 1'b1;
               mac_result = e.data;
               @(negedge clk);
               mac_done = 1'b0;
               if (model_oc == OUT - 1) begin
                  model_oc = 0;
                  model_pix++;
               end else begin
                  model_oc++;
               end
            end
         end
         last_addr = wgt_addr;
      end
   end

   // Monitor: compares every presented result against the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (win_advance) adv_cnt++;
            if (res_valid) begin
               check("no_mac_start_in_output", mac_start, 0);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_empty: got result 0x%0h, expected no result", res_data);
               end else begin
                  check(res_ready ? "res_data" : "hold_res_data", res_data, sb[0].data);
                  check(res_ready ? "res_oc" : "hold_res_oc", res_oc, sb[0].oc);
                  if (res_ready) begin
                     void'(sb.pop_front());
                     accepts++;
                  end
               end
            end
            if (frame_done) begin
               fd_cnt++;
               check("frame_done_after_16", accepts, 16);
               check("frame_done_with_advance", win_advance, 1);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; frame_start = 1'b0; win_valid = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_mac_start", mac_start, 0);
      check("rst_win_advance", win_advance, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_wgt_addr", wgt_addr, 0);
      check("rst_ch_sel", ch_sel, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_oc", res_oc, 0);
      rst = 1'b0;

      // Frame A: free-flowing, with a frame_start pulse mid-frame that must be ignored
      win_valid = 1'b1;
      res_ready = 1'b1;
      start_frame();
      wait_high(2, 40, "A_first_mac_start");
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      wait_high(0, 2000, "A_frame_done");
      end_of_frame("A");

      // Frame B: back-pressure on the first result, then window stall after the first pixel
      res_ready    = 1'b0;
      override_val = 16'h1234;
      override_en  = 1'b1;
      start_frame();
      wait_high(1, 40, "B_res_valid");
      repeat (10) @(negedge clk);
      check("B_bp_data", res_data, 16'h1234);
      check("B_bp_valid", res_valid, 1);
      res_ready = 1'b1;
      wait_high(3, 60, "B_first_advance");
      win_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("B_stall_no_start", mac_start, 0);
         check("B_stall_addr_held", wgt_addr, 7);
         check("B_stall_busy", busy, 1);
      end
      win_valid = 1'b1;
      @(negedge clk);
      check("B_resume_addr", wgt_addr, 0);
      check("B_resume_no_start_yet", mac_start, 0);
      @(negedge clk);
      check("B_resume_start", mac_start, 1);
      wait_high(0, 2000, "B_frame_done");
      end_of_frame("B");

      // Frame C: reset during ISSUE
      start_frame();
      wait_high(2, 40, "C_mac_start");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("C_rst_busy", busy, 0);
      check("C_rst_mac_start", mac_start, 0);
      check("C_rst_res_valid", res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("C_idle_busy", busy, 0);
      check("C_no_frame_done", fd_cnt, 0);
      check("C_no_results", sb.size(), 0);

      // Frame D: restart after reset begins at oc=0 and completes normally
      start_frame();
      wait_high(0, 2000, "D_frame_done");
      end_of_frame("D");

`ifdef MAC_WDOG_EN
      mac_silent = 1'b1;
      start_frame();
      wait_high(4, 60, "W_wdog_err");
      @(negedge clk);
      check("W_busy", busy, 0);
      check("W_no_frame_done", fd_cnt, 0);
      mac_silent = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
